pll_reconfig_ctrl: RTL and testbench

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

---
 rtl/pll_reconfig_pkg.sv | 65 ++++++
 rtl/pll_reconfig_ctrl_avmm_writer.sv | 54 +++++
 rtl/pll_reconfig_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared types, register map and divider table for the PLL reconfiguration
// controller and its Avalon-MM write helper.
package pll_reconfig_pkg;

  // Controller sequence states
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WR_MODE     = 3'd1,
    ST_WR_C        = 3'd2,
    ST_WR_START    = 3'd3,
    ST_WAIT_UNLOCK = 3'd4,
    ST_WAIT_LOCK   = 3'd5,
    ST_FINISH      = 3'd6,
    ST_FAIL        = 3'd7
  } state_t;

  // Reconfig core register addresses
  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_C_CNT = 6'd5;

  // Fixed write payloads: waitrequest mode select, and the start trigger
  localparam logic [31:0] MODE_WAITREQ = 32'd0;
  localparam logic [31:0] START_GO     = 32'd1;

  // Cycles to wait for lock to drop before assuming it never will
  localparam int UNLOCK_SKIP_CYCLES = 16;

  // One output counter setting: high/low VCO cycle counts and odd-divide flag
  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       odd;
  } div_t;

  // 800 MHz VCO divides: 3.587, 5.369, 7.143, 9.524 MHz
  localparam div_t PROFILE_TABLE [4] = '{
    '{hi: 8'd112, lo: 8'd111, odd: 1'b1},
    '{hi: 8'd75,  lo: 8'd74,  odd: 1'b1},
    '{hi: 8'd56,  lo: 8'd56,  odd: 1'b0},
    '{hi: 8'd42,  lo: 8'd42,  odd: 1'b0}
  };

  // C-counter word field positions
  localparam int CW_IDX_LSB = 18;
  localparam int CW_ODD_BIT = 17;
  localparam int CW_BYP_BIT = 16;
  localparam int CW_HI_LSB  = 8;
  localparam int CW_LO_LSB  = 0;

  // Build the C-counter register word for a counter index and profile
  function automatic logic [31:0] c_word(input logic [4:0] cidx, input logic [1:0] prof);
    logic [31:0] w;
    div_t        d;
    d = PROFILE_TABLE[prof];
    w = '0;
    w[CW_IDX_LSB +: 5] = cidx;
    w[CW_ODD_BIT]      = d.odd;
    w[CW_BYP_BIT]      = 1'b0;
    w[CW_HI_LSB +: 8]  = d.hi;
    w[CW_LO_LSB +: 8]  = d.lo;
    return w;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_avmm_writer.sv
// Single Avalon-MM write: holds write/address/data until the slave drops
// waitrequest, or gives up after TIMEOUT stalled cycles.
module pll_avmm_writer #(
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [5:0]  i_addr,
  input  logic [31:0] i_data,
  input  logic        i_waitrequest,
  output logic        o_write,
  output logic [5:0]  o_address,
  output logic [31:0] o_writedata,
  output logic        o_done,
  output logic        o_timeout
);

  localparam logic [15:0] C_TMO = 16'(TIMEOUT);

  logic        r_write;
  logic [5:0]  r_addr;
  logic [31:0] r_data;
  logic [15:0] r_cnt;

  assign o_done      = r_write & ~i_waitrequest;
  assign o_timeout   = r_write & i_waitrequest & (r_cnt == C_TMO);
  assign o_write     = r_write;
  assign o_address   = r_addr;
  assign o_writedata = r_data;

  // Launch, hold and retire one write; address/data are zeroed whenever idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (i_start && !r_write) begin
      r_write <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
      r_cnt   <= '0;
    end else if (o_done || o_timeout) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (r_write) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Retunes one PLL output counter to one of four speed profiles through the
// reconfig core's Avalon-MM port, then waits for the PLL to relock.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int C_INDEX      = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  speed_sel,
  input  logic        speed_req,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  cur_profile,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam logic [15:0] C_TMO  = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] C_SKIP = 16'(UNLOCK_SKIP_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic        r_lock_s1;
  logic        r_lock_s2;
  logic        r_rdy;
  logic        r_pend_vld;
  logic [1:0]  r_pend_sel;
  logic [1:0]  r_req_sel;
  logic [1:0]  r_cur;
  logic        r_err;

  logic        w_req_vld;
  logic [1:0]  w_req_sel;
  logic        w_accept;
  logic        w_wr_state;
  logic        w_wr_start;
  logic [5:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic        w_wr_done;
  logic        w_wr_tmo;
  logic        w_tmo_hit;

  // A fresh strobe overrides anything pending; r_rdy holds off the first edge after reset
  assign w_req_vld  = speed_req | r_pend_vld;
  assign w_req_sel  = speed_req ? speed_sel : r_pend_sel;
  assign w_accept   = (r_state == ST_IDLE) & r_rdy & w_req_vld;
  assign w_wr_state = (r_state == ST_WR_MODE) | (r_state == ST_WR_C) | (r_state == ST_WR_START);
  assign w_wr_start = w_wr_state & (r_cnt == 16'd0);
  assign w_tmo_hit  = (r_cnt == C_TMO);

  assign error       = r_err;
  assign cur_profile = r_cur;

  // Two-flop synchroniser for the asynchronous lock indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= pll_locked;
      r_lock_s2 <= r_lock_s1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state, bus payload per write state, and status decode
  always_comb begin
    w_next    = r_state;
    w_wr_addr = '0;
    w_wr_data = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = (w_req_sel != r_cur) ? ST_WR_MODE : ST_FINISH;
      end
      ST_WR_MODE: begin
        busy      = 1'b1;
        w_wr_addr = ADDR_MODE;
        w_wr_data = MODE_WAITREQ;
        if (w_wr_done)     w_next = ST_WR_C;
        else if (w_wr_tmo) w_next = ST_FAIL;
      end
      ST_WR_C: begin
        busy      = 1'b1;
        w_wr_addr = ADDR_C_CNT;
        w_wr_data = c_word(5'(C_INDEX), r_req_sel);
        if (w_wr_done)     w_next = ST_WR_START;
        else if (w_wr_tmo) w_next = ST_FAIL;
      end
      ST_WR_START: begin
        busy      = 1'b1;
        w_wr_addr = ADDR_START;
        w_wr_data = START_GO;
        if (w_wr_done)     w_next = ST_WAIT_UNLOCK;
        else if (w_wr_tmo) w_next = ST_FAIL;
      end
      ST_WAIT_UNLOCK: begin
        busy = 1'b1;
        // Some retunes never visibly drop lock; stop waiting after a short window
        if (!r_lock_s2 || (r_cnt == C_SKIP)) w_next = ST_WAIT_LOCK;
        else if (w_tmo_hit)                  w_next = ST_FAIL;
      end
      ST_WAIT_LOCK: begin
        busy = 1'b1;
        if (r_lock_s2)      w_next = ST_FINISH;
        else if (w_tmo_hit) w_next = ST_FAIL;
      end
      ST_FINISH: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      ST_FAIL: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-state cycle counter, restarted on every state entry and saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) || (r_state == ST_IDLE)) begin
      r_cnt <= '0;
    end else if (r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Request bookkeeping: pending slot, applied profile and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy      <= 1'b0;
      r_pend_vld <= 1'b0;
      r_pend_sel <= '0;
      r_req_sel  <= '0;
      r_cur      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (w_accept) begin
        r_req_sel  <= w_req_sel;
        r_pend_vld <= 1'b0;
        r_err      <= 1'b0;
      end else if (speed_req) begin
        r_pend_vld <= 1'b1;
        r_pend_sel <= speed_sel;
      end
      if ((r_state == ST_WAIT_LOCK) && (w_next == ST_FINISH)) r_cur <= r_req_sel;
      if ((w_next == ST_FAIL) && (r_state != ST_FAIL))       r_err <= 1'b1;
    end
  end

  pll_avmm_writer #(
    .TIMEOUT (LOCK_TIMEOUT)
  ) u_writer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (w_wr_start),
    .i_addr        (w_wr_addr),
    .i_data        (w_wr_data),
    .i_waitrequest (mgmt_waitrequest),
    .o_write       (mgmt_write),
    .o_address     (mgmt_address),
    .o_writedata   (mgmt_writedata),
    .o_done        (w_wr_done),
    .o_timeout     (w_wr_tmo)
  );

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl with a behavioural PLL / reconfig-core model.
module tb_pll_reconfig_ctrl;

  localparam int TMO  = 100;
  localparam int CIDX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  speed_sel = 2'd0;
  logic        speed_req = 1'b0;
  logic        busy, done, error;
  logic [1:0]  cur_profile;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b1;

  always #10 clk = ~clk;

  pll_reconfig_ctrl #(.C_INDEX(CIDX), .LOCK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .speed_sel(speed_sel), .speed_req(speed_req),
    .busy(busy), .done(done), .error(error), .cur_profile(cur_profile),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
    .pll_locked(pll_locked)
  );

  int total = 0;
  int bad   = 0;

  // kind: 0 = write accepted, 1 = done pulse, 2 = error raised
  typedef struct {
    int          kind;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [1:0]  prof;
  } ev_t;
  ev_t exp_q[$];

  int m_cur     = 0;
  int hold_cfg  = -1;
  int lock_mode = 0;   // 0 drop then relock, 1 never drops, 2 drops and never relocks
  int hi_t[4]  = '{112, 75, 56, 42};
  int lo_t[4]  = '{111, 74, 56, 42};
  int odd_t[4] = '{1, 1, 0, 0};

  function automatic logic [31:0] m_cword(input int sel);
    return 32'(CIDX * 262144 + odd_t[sel] * 131072 + hi_t[sel] * 256 + lo_t[sel]);
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push(input int kind, input logic [5:0] a, input logic [31:0] d, input int p);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.prof = 2'(p);
    exp_q.push_back(e);
  endfunction

  // Reference behaviour of one request, in the order it is serviced
  function automatic void model_req(input int sel, input bit relock_ok, input bit wr_timeout);
    if (sel == m_cur) begin
      push(1, 6'd0, 32'd0, sel);
    end else if (wr_timeout) begin
      push(2, 6'd0, 32'd0, m_cur);
    end else begin
      push(0, 6'd0, 32'd0, 0);
      push(0, 6'd5, m_cword(sel), 0);
      push(0, 6'd2, 32'd1, 0);
      if (relock_ok) begin
        push(1, 6'd0, 32'd0, sel);
        m_cur = sel;
      end else begin
        push(2, 6'd0, 32'd0, m_cur);
      end
    end
  endfunction

  task automatic strobe(input logic [1:0] sel);
    @(posedge clk); #1;
    speed_sel = sel;
    speed_req = 1'b1;
    @(posedge clk); #1;
    speed_req = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_cur"}, cur_profile, 0);
    check({tag, "_write"}, mgmt_write, 0);
    check({tag, "_addr"}, mgmt_address, 0);
    check({tag, "_data"}, mgmt_writedata, 0);
  endtask

  // Reconfig core stall model: hold each write hold_cfg cycles (random 0..3 if negative)
  int hold_left = 0;
  always @(posedge clk) begin
    #1;
    if (mgmt_write) begin
      if (hold_left > 0) begin
        mgmt_waitrequest = 1'b1;
        hold_left--;
      end else begin
        mgmt_waitrequest = 1'b0;
      end
    end else begin
      mgmt_waitrequest = 1'b0;
      hold_left = (hold_cfg < 0) ? int'($urandom_range(3, 0)) : hold_cfg;
    end
  end

  // PLL model: reacts to the start-register write
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mgmt_write && !mgmt_waitrequest && mgmt_address == 6'd2) begin
        if (lock_mode == 0) begin
          repeat (int'($urandom_range(4, 1))) @(posedge clk);
          #1 pll_locked = 1'b0;
          repeat (int'($urandom_range(12, 2))) @(posedge clk);
          #1 pll_locked = 1'b1;
        end else if (lock_mode == 2) begin
          @(posedge clk);
          #1 pll_locked = 1'b0;
          for (int k = 0; k < 600 && !error; k++) @(posedge clk);
          repeat (3) @(posedge clk);
          #1 pll_locked = 1'b1;
        end
      end
    end
  end

  // Monitor: bus protocol checks and scoreboard pops
  logic        prev_hold = 1'b0;
  logic        prev_hs   = 1'b0;
  logic        prev_err  = 1'b0;
  logic [5:0]  prev_addr = '0;
  logic [31:0] prev_data = '0;
  int          wr_len    = 0;
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_hs   = 1'b0;
      prev_err  = 1'b0;
      wr_len    = 0;
    end else begin
      if (!mgmt_write) check("idle_bus_zero", 32'(mgmt_address) | mgmt_writedata, 32'd0);
      if (prev_hs) check("write_gap", mgmt_write, 0);
      if (prev_hold && !(error && !prev_err)) begin
        check("hold_write", mgmt_write, 1);
        check("hold_addr", mgmt_address, prev_addr);
        check("hold_data", mgmt_writedata, prev_data);
      end
      if (mgmt_write) begin
        wr_len++;
        check("busy_in_write", busy, 1);
      end
      if (mgmt_write && !mgmt_waitrequest) begin
        if (hold_cfg >= 0) check("write_len", 32'(wr_len), 32'(hold_cfg + 1));
        wr_len = 0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mgmt_address, mgmt_writedata);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_write", 32'(e.kind), 32'd0);
          check("write_addr", mgmt_address, e.addr);
          check("write_data", mgmt_writedata, e.data);
        end
      end
      if (!mgmt_write) wr_len = 0;
      if (done) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: cur_profile %0d, none expected", cur_profile);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_done", 32'(e.kind), 32'd1);
          check("done_profile", cur_profile, e.prof);
          check("done_busy", busy, 0);
        end
      end
      if (error && !prev_err) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_error: error rose, none expected");
        end else begin
          e = exp_q.pop_front();
          check("event_kind_error", 32'(e.kind), 32'd2);
          check("error_profile_kept", cur_profile, e.prof);
          check("error_busy", busy, 0);
          check("error_write", mgmt_write, 0);
        end
      end
      prev_hold = mgmt_write && mgmt_waitrequest;
      prev_hs   = mgmt_write && !mgmt_waitrequest;
      prev_addr = mgmt_address;
      prev_data = mgmt_writedata;
      prev_err  = error;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, sel2, found;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Same profile as current: no bus traffic, done on the second edge
    model_req(0, 1, 0);
    @(posedge clk); #1;
    speed_sel = 2'd0; speed_req = 1'b1;
    @(negedge clk);
    check("same_done_early", done, 0);
    @(posedge clk); #1 speed_req = 1'b0;
    @(negedge clk);
    check("same_done_timing", done, 1);
    wait_idle(50, "drain_same");

    // Profile 2, no stalls
    hold_cfg = 0; lock_mode = 0;
    model_req(2, 1, 0); strobe(2'd2);
    wait_idle(400, "drain_sel2");
    check("cur_sel2", cur_profile, 32'(m_cur));

    // Profile 1, each write stalled 5 cycles
    hold_cfg = 5;
    model_req(1, 1, 0); strobe(2'd1);
    wait_idle(400, "drain_sel1");
    check("cur_sel1", cur_profile, 32'(m_cur));

    // Profile 3, PLL never relocks
    hold_cfg = -1; lock_mode = 2;
    model_req(3, 0, 0); strobe(2'd3);
    wait_idle(800, "drain_nolock");
    check("nolock_error", error, 1);
    check("nolock_busy", busy, 0);
    check("nolock_cur", cur_profile, 32'(m_cur));
    repeat (8) @(posedge clk);

    // Next request clears the error
    lock_mode = 0;
    model_req(2, 1, 0); strobe(2'd2);
    @(negedge clk);
    check("err_cleared", error, 0);
    check("busy_after_accept", busy, 1);
    wait_idle(400, "drain_recover");

    // Bus write never accepted
    hold_cfg = 300;
    model_req(0, 1, 1); strobe(2'd0);
    wait_idle(800, "drain_wrtmo");
    check("wrtmo_error", error, 1);
    check("wrtmo_cur", cur_profile, 32'(m_cur));

    // Three strobes, two during busy: only the latest pending one follows
    hold_cfg = -1; lock_mode = 0;
    model_req(1, 1, 0); strobe(2'd1);
    repeat (2) @(posedge clk);
    strobe(2'd3);
    model_req(2, 1, 0); strobe(2'd2);
    wait_idle(800, "drain_pending");
    check("cur_pending", cur_profile, 2);

    // Randomised requests, sometimes with a second strobe close behind
    for (int it = 0; it < 20; it++) begin
      sel = int'($urandom_range(3, 0));
      lock_mode = int'($urandom_range(1, 0));
      hold_cfg = -1;
      model_req(sel, 1, 0); strobe(2'(sel));
      if ($urandom_range(2, 0) == 0) begin
        sel2 = int'($urandom_range(3, 0));
        repeat (int'($urandom_range(3, 0))) @(posedge clk);
        model_req(sel2, 1, 0); strobe(2'(sel2));
      end
      wait_idle(800, "drain_random");
      check("cur_random", cur_profile, 32'(m_cur));
    end

    // Reset during the C-counter write, then a normal request
    hold_cfg = 8; lock_mode = 0;
    sel = (m_cur + 1) % 4;
    model_req(sel, 1, 0); strobe(2'(sel));
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(negedge clk);
      if (mgmt_write && mgmt_address == 6'd5) found = 1;
    end
    check("reach_wr_c", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    m_cur = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hold_cfg = -1;
    model_req(3, 1, 0); strobe(2'd3);
    wait_idle(400, "drain_after_reset");
    check("cur_after_reset", cur_profile, 3);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
